gcd_vector_sequencer: RTL and testbench
=======================================

# gcd_vector_sequencer

Synthesizable, parametrised successor to the GCD simulation bench. It holds a small vector RAM of (a, b, expected gcd) triples and runs them back-to-back against the pseudo-CPU core. For each vector it resets the core, loads operands, enables it, waits for the control unit to reach the finish address (with timeout), lets it settle, and compares the result. It sits beside `top` and replaces the `$readmemb`/hierarchical-poke flow with a port-level, on-chip test sequencer that reports pass/fail/timeout counts.

## Interface
- `WIDTH`, 32, operand/result width
- `IDX_W`, 4, vector index width; `DEPTH = 2**IDX_W` entries
- `ADDR_W`, 4, control-unit instruction address width
- `FIN_ADDR`, 9, address that marks program completion
- `RST_CYCLES`, 1, cycles `dut_rst` is held per vector (≥1)
- `SETTLE_CYCLES`, 10, cycles waited after `FIN_ADDR` before compare (≥0)
- `TIMEOUT`, 4096, maximum RUN cycles per vector (≥1)

- `clk` in 1: single clock
- `rst` in 1: synchronous, active-high reset
- `start` in 1: begin a run; honoured only in IDLE or DONE
- `n_tests` in IDX_W+1: number of vectors to run (0..DEPTH), sampled at `start`
- `vec_we` in 1: vector RAM write strobe; ignored while `busy`
- `vec_idx` in IDX_W: write index
- `vec_a`, `vec_b`, `vec_g` in WIDTH each: operand a, operand b, expected gcd
- `dut_rst` out 1: reset to the core
- `dut_en` out 1: enable to the core
- `dut_ld` out 1: one-cycle operand load strobe
- `dut_a`, `dut_b` out WIDTH each: operands presented with `dut_ld`
- `dut_addr` in ADDR_W: current control-unit address
- `dut_res` in WIDTH: core result register (`a`)
- `busy` out 1: run in progress
- `done` out 1: run complete; level, cleared by next accepted `start` or `rst`
- `pass_cnt`, `fail_cnt`, `timeout_cnt` out IDX_W+1 each: counters
- `first_fail_vld` out 1; `first_fail_idx` out IDX_W: index of the first failing vector

## Operation
- States: IDLE, DRST, LOAD, RUN, SETTLE, CHECK, DONE.
- IDLE/DONE:
  - `dut_rst`=1, `dut_en`=0.
  - `start` clears all counters and `first_fail_vld`, latches `n_tests`, sets idx=0.
  - Goes to DRST, or directly to DONE if `n_tests`=0.
- DRST: `dut_rst`=1 for RST_CYCLES cycles, then LOAD.
- LOAD: one cycle; `dut_rst`=0, `dut_en`=0, `dut_ld`=1, `dut_a`/`dut_b` = RAM[idx].a/.b.
- RUN:
  - `dut_en`=1; cycle timer counts from 1.
  - `dut_addr`==FIN_ADDR sampled → SETTLE.
  - Otherwise timer==TIMEOUT → CHECK with timeout flag set.
- SETTLE: `dut_en` stays 1 for SETTLE_CYCLES cycles, then CHECK. SETTLE_CYCLES=0 means RUN goes directly to CHECK.
- CHECK: one cycle.
  - Timeout flag set → `timeout_cnt`++ and `fail_cnt`++.
  - Else `dut_res`==RAM[idx].g → `pass_cnt`++, otherwise `fail_cnt`++.
  - First fail sets `first_fail_vld`/`first_fail_idx`.
  - idx++; idx==n_tests → DONE, else DRST.
- The compare is full WIDTH-bit equality. Counters saturate at all-ones. Invariant: pass_cnt+fail_cnt = vectors checked.
- Vector RAM is not reset. Writes land at the clock edge; `vec_we` is ignored when `busy`=1.
- `start` while `busy` is ignored.
- `rst` at any time: next cycle IDLE with reset values. RAM contents are retained.

## Timing
- Reset values: `dut_rst`=1, `dut_en`=0, `dut_ld`=0, `dut_a`=`dut_b`=0, `busy`=0, `done`=0, all counters 0, `first_fail_vld`=0, `first_fail_idx`=0.
- `start` accepted at edge T: `busy`=1 and `done`=0 from T+1. `dut_rst` high for T+1..T+RST_CYCLES.
- LOAD follows in the next cycle. RUN begins the cycle after LOAD.
- Per-vector latency = RST_CYCLES + 1 + R + SETTLE_CYCLES + 1, where R = RUN cycles (including the cycle FIN_ADDR is seen; R=TIMEOUT on timeout).
- `busy` falls and `done` rises in the same cycle DONE is entered. Counters are final in that cycle.
- `n_tests`=0: `done`=1 at T+1, `busy` stays 0.
- All outputs are registered.

## Test plan
- Load (12,18,6),(17,5,1),(1071,462,21); `n_tests`=3; behavioural core model → `pass_cnt`=3, `fail_cnt`=0, `done`=1, `first_fail_vld`=0.
- Same vectors, but vector 1 has g=2 → `pass_cnt`=2, `fail_cnt`=1, `first_fail_idx`=1, `timeout_cnt`=0.
- Core model never reaches FIN_ADDR, TIMEOUT=64, `n_tests`=1 → RUN lasts exactly 64 cycles, `timeout_cnt`=1, `fail_cnt`=1.
- `n_tests`=0 → `done`=1 one cycle after `start`, all counters 0, `dut_en` never 1.
- `rst` pulsed mid-RUN of vector 1 → next cycle all outputs at reset values; rerun with `start` → 3 passes (RAM retained).
- `start` pulses and `vec_we` writes during `busy` → run unaffected, RAM unchanged, identical counts to the undisturbed run.

Source files
------------

// File: rtl/gcd_vector_sequencer.sv
// rtl/gcd_vector_sequencer.sv - on-chip vector sequencer that runs stored (a, b, gcd) triples against the GCD core
// Each vector: reset core, load operands, run to FIN_ADDR (or timeout), settle, compare result.
module gcd_vector_sequencer #(
  parameter int WIDTH         = 32,
  parameter int IDX_W         = 4,
  parameter int ADDR_W        = 4,
  parameter int FIN_ADDR      = 9,
  parameter int RST_CYCLES    = 1,
  parameter int SETTLE_CYCLES = 10,
  parameter int TIMEOUT       = 4096
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [IDX_W:0]    n_tests,
  input  logic              vec_we,
  input  logic [IDX_W-1:0]  vec_idx,
  input  logic [WIDTH-1:0]  vec_a,
  input  logic [WIDTH-1:0]  vec_b,
  input  logic [WIDTH-1:0]  vec_g,
  output logic              dut_rst,
  output logic              dut_en,
  output logic              dut_ld,
  output logic [WIDTH-1:0]  dut_a,
  output logic [WIDTH-1:0]  dut_b,
  input  logic [ADDR_W-1:0] dut_addr,
  input  logic [WIDTH-1:0]  dut_res,
  output logic              busy,
  output logic              done,
  output logic [IDX_W:0]    pass_cnt,
  output logic [IDX_W:0]    fail_cnt,
  output logic [IDX_W:0]    timeout_cnt,
  output logic              first_fail_vld,
  output logic [IDX_W-1:0]  first_fail_idx
);

  localparam int DEPTH = 2 ** IDX_W;
  localparam int CNT_W = IDX_W + 1;
  localparam int RC_W  = $clog2(RST_CYCLES + 1);
  localparam int SC_W  = (SETTLE_CYCLES > 0) ? $clog2(SETTLE_CYCLES + 1) : 1;
  localparam int TM_W  = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, DRST, LOAD, RUN, SETTLE, CHECK, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] ram_a [DEPTH];
  logic [WIDTH-1:0] ram_b [DEPTH];
  logic [WIDTH-1:0] ram_g [DEPTH];
  logic [CNT_W-1:0] idx;
  logic [CNT_W-1:0] n_lat;
  logic [IDX_W-1:0] ridx;
  logic [RC_W-1:0]  rcnt;
  logic [SC_W-1:0]  scnt;
  logic [TM_W-1:0]  tmr;
  logic             tmo;

  assign ridx = idx[IDX_W-1:0];

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // Vector RAM has no reset so contents survive rst; host writes are locked out during a run.
  always_ff @(posedge clk) begin
    if (vec_we && !busy) begin
      ram_a[vec_idx] <= vec_a;
      ram_b[vec_idx] <= vec_b;
      ram_g[vec_idx] <= vec_g;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      dut_rst        <= 1'b1;
      dut_en         <= 1'b0;
      dut_ld         <= 1'b0;
      dut_a          <= '0;
      dut_b          <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass_cnt       <= '0;
      fail_cnt       <= '0;
      timeout_cnt    <= '0;
      first_fail_vld <= 1'b0;
      first_fail_idx <= '0;
      idx            <= '0;
      n_lat          <= '0;
      rcnt           <= '0;
      scnt           <= '0;
      tmr            <= '0;
      tmo            <= 1'b0;
    end else begin
      dut_ld <= 1'b0;
      case (state)
        IDLE, DONE: begin
          dut_rst <= 1'b1;
          dut_en  <= 1'b0;
          if (start) begin
            pass_cnt       <= '0;
            fail_cnt       <= '0;
            timeout_cnt    <= '0;
            first_fail_vld <= 1'b0;
            n_lat          <= n_tests;
            idx            <= '0;
            if (n_tests == '0) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              state <= DRST;
              rcnt  <= RC_W'(1);
              busy  <= 1'b1;
              done  <= 1'b0;
            end
          end
        end
        DRST: begin
          if (rcnt == RC_W'(RST_CYCLES)) begin
            state   <= LOAD;
            dut_rst <= 1'b0;
            dut_ld  <= 1'b1;
            dut_a   <= ram_a[ridx];
            dut_b   <= ram_b[ridx];
          end else begin
            rcnt <= rcnt + 1'b1;
          end
        end
        LOAD: begin
          state  <= RUN;
          dut_en <= 1'b1;
          tmr    <= TM_W'(1);
          tmo    <= 1'b0;
        end
        RUN: begin
          // Reaching FIN_ADDR wins over a timeout that expires in the same cycle.
          if (dut_addr == ADDR_W'(FIN_ADDR)) begin
            if (SETTLE_CYCLES == 0) begin
              state  <= CHECK;
              dut_en <= 1'b0;
            end else begin
              state <= SETTLE;
              scnt  <= SC_W'(1);
            end
          end else if (tmr == TM_W'(TIMEOUT)) begin
            state  <= CHECK;
            tmo    <= 1'b1;
            dut_en <= 1'b0;
          end else begin
            tmr <= tmr + 1'b1;
          end
        end
        SETTLE: begin
          if (scnt == SC_W'(SETTLE_CYCLES)) begin
            state  <= CHECK;
            dut_en <= 1'b0;
          end else begin
            scnt <= scnt + 1'b1;
          end
        end
        CHECK: begin
          if (tmo || (dut_res != ram_g[ridx])) begin
            fail_cnt <= sat_inc(fail_cnt);
            if (tmo) timeout_cnt <= sat_inc(timeout_cnt);
            if (!first_fail_vld) begin
              first_fail_vld <= 1'b1;
              first_fail_idx <= ridx;
            end
          end else begin
            pass_cnt <= sat_inc(pass_cnt);
          end
          idx     <= idx + 1'b1;
          dut_rst <= 1'b1;
          if (idx + 1'b1 == n_lat) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            state <= DRST;
            rcnt  <= RC_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gcd_vector_sequencer.sv
// tb/tb_gcd_vector_sequencer.sv - scoreboard bench for gcd_vector_sequencer with a behavioural subtract-GCD core
module tb_gcd_vector_sequencer;
  localparam int WIDTH = 32;
  localparam int IDX_W = 4;
  localparam int ADDR_W = 4;
  localparam int TMO = 64;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic [IDX_W:0]    n_tests = '0;
  logic              vec_we = 1'b0;
  logic [IDX_W-1:0]  vec_idx = '0;
  logic [WIDTH-1:0]  vec_a = '0, vec_b = '0, vec_g = '0;
  logic              dut_rst, dut_en, dut_ld;
  logic [WIDTH-1:0]  dut_a, dut_b;
  logic [ADDR_W-1:0] dut_addr;
  logic [WIDTH-1:0]  dut_res;
  logic              busy, done;
  logic [IDX_W:0]    pass_cnt, fail_cnt, timeout_cnt;
  logic              first_fail_vld;
  logic [IDX_W-1:0]  first_fail_idx;

  always #5 clk = ~clk;

  gcd_vector_sequencer #(.TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .start(start), .n_tests(n_tests),
    .vec_we(vec_we), .vec_idx(vec_idx), .vec_a(vec_a), .vec_b(vec_b), .vec_g(vec_g),
    .dut_rst(dut_rst), .dut_en(dut_en), .dut_ld(dut_ld), .dut_a(dut_a), .dut_b(dut_b),
    .dut_addr(dut_addr), .dut_res(dut_res), .busy(busy), .done(done),
    .pass_cnt(pass_cnt), .fail_cnt(fail_cnt), .timeout_cnt(timeout_cnt),
    .first_fail_vld(first_fail_vld), .first_fail_idx(first_fail_idx)
  );

  // Core model: one subtraction per enabled cycle, address 9 once a == b unless hung.
  logic [WIDTH-1:0]  ca = '0, cb = '0;
  logic [ADDR_W-1:0] caddr = '0;
  logic              hang = 1'b0;
  assign dut_addr = caddr;
  assign dut_res  = ca;

  always @(posedge clk) begin
    if (dut_rst) begin
      ca <= '0; cb <= '0; caddr <= '0;
    end else if (dut_ld) begin
      ca <= dut_a; cb <= dut_b; caddr <= 4'd1;
    end else if (dut_en) begin
      if (ca != cb && ca != 0 && cb != 0) begin
        if (ca > cb) ca <= ca - cb; else cb <= cb - ca;
        caddr <= (caddr >= 4'd8) ? 4'd2 : caddr + 4'd1;
      end else if (!hang) caddr <= 4'd9;
      else caddr <= (caddr >= 4'd8) ? 4'd2 : caddr + 4'd1;
    end
  end

  int n_checks = 0, n_pass = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  typedef struct { int p; int f; int t; int fv; int fi; } res_t;
  res_t        expq[$];
  logic [63:0] opq[$];
  logic [WIDTH-1:0] sa [16], sb [16], sg [16];

  function automatic logic [WIDTH-1:0] gcd_ref(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    logic [WIDTH-1:0] t;
    while (b != 0) begin t = a % b; a = b; b = t; end
    return a;
  endfunction

  // Monitor: operand scoreboard on each load, final-count scoreboard on each rise of done.
  logic done_q = 1'b0;
  int en_run = 0, ld_seen = 0;
  always @(negedge clk) begin
    res_t e;
    logic [63:0] o;
    if (dut_ld) begin
      ld_seen++;
      en_run = 0;
      if (opq.size() == 0) check("ld_unexpected", 1, 0);
      else begin
        o = opq.pop_front();
        check("dut_a", dut_a, o[63:32]);
        check("dut_b", dut_b, o[31:0]);
      end
    end
    if (dut_en) en_run++;
    if (done && !done_q) begin
      if (expq.size() == 0) check("done_unexpected", 1, 0);
      else begin
        e = expq.pop_front();
        check("pass_cnt", pass_cnt, e.p);
        check("fail_cnt", fail_cnt, e.f);
        check("timeout_cnt", timeout_cnt, e.t);
        check("first_fail_vld", first_fail_vld, e.fv);
        if (e.fv != 0) check("first_fail_idx", first_fail_idx, e.fi);
        check("busy_at_done", busy, 0);
      end
    end
    done_q = done;
  end

  task automatic write_vec(input int i, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                           input logic [WIDTH-1:0] g);
    vec_we = 1'b1; vec_idx = i[IDX_W-1:0]; vec_a = a; vec_b = b; vec_g = g;
    if (!busy) begin sa[i] = a; sb[i] = b; sg[i] = g; end
    @(negedge clk);
    vec_we = 1'b0;
  endtask

  task automatic launch(input int n);
    res_t e;
    e = '{default: 0};
    for (int i = 0; i < n; i++) begin
      opq.push_back({sa[i], sb[i]});
      if (!hang && gcd_ref(sa[i], sb[i]) == sg[i]) e.p++;
      else begin
        e.f++;
        if (hang) e.t++;
        if (e.fv == 0) begin e.fv = 1; e.fi = i; end
      end
    end
    expq.push_back(e);
    start = 1'b1; n_tests = n[IDX_W:0];
    @(negedge clk);
    start = 1'b0;
    check("busy_after_start", busy, 1);
    check("done_after_start", done, 0);
    check("dut_rst_after_start", dut_rst, 1);
  endtask

  task automatic wait_done(input int budget);
    int k = 0;
    while (!done && k < budget) begin @(negedge clk); k++; end
    check("done_in_budget", done, 1);
  endtask

  task automatic check_reset();
    check("rst_dut_rst", dut_rst, 1);
    check("rst_dut_en", dut_en, 0);
    check("rst_dut_ld", dut_ld, 0);
    check("rst_dut_a", dut_a, 0);
    check("rst_dut_b", dut_b, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_counts", {pass_cnt, fail_cnt, timeout_cnt}, 0);
    check("rst_ff", {first_fail_vld, first_fail_idx}, 0);
  endtask

  initial begin
    int k;
    int en_seen;
    repeat (3) @(negedge clk);
    check_reset();
    rst = 1'b0;

    write_vec(0, 12, 18, 6);
    write_vec(1, 17, 5, 1);
    write_vec(2, 1071, 462, 21);
    launch(3); wait_done(5000);

    write_vec(1, 17, 5, 2);
    launch(3); wait_done(5000);

    write_vec(1, 17, 5, 1);
    hang = 1'b1;
    launch(1); wait_done(5000);
    check("timeout_run_len", en_run, TMO);
    hang = 1'b0;

    start = 1'b1; n_tests = '0;
    @(negedge clk);
    start = 1'b0;
    check("n0_done", done, 1);
    check("n0_busy", busy, 0);
    check("n0_counts", {pass_cnt, fail_cnt, timeout_cnt}, 0);
    en_seen = 0;
    repeat (5) begin if (dut_en) en_seen = 1; @(negedge clk); end
    check("n0_no_en", en_seen, 0);

    ld_seen = 0;
    launch(3);
    k = 0;
    while (ld_seen < 2 && k < 500) begin @(negedge clk); k++; end
    check("reached_vec1", ld_seen, 2);
    @(negedge clk); @(negedge clk);
    check("mid_run_en", dut_en, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    opq.delete(); expq.delete();
    check_reset();
    launch(3); wait_done(5000);

    launch(3);
    for (int i = 0; i < 6; i++) begin
      start = (i % 2 == 0); n_tests = 1;
      vec_we = 1'b1; vec_idx = (i % 2 == 0) ? 4'd1 : 4'd2;
      vec_a = 99 + i; vec_b = 7; vec_g = 5;
      @(negedge clk);
    end
    start = 1'b0; vec_we = 1'b0; n_tests = '0;
    wait_done(5000);
    launch(3); wait_done(5000);

    repeat (5) @(negedge clk);
    check("opq_empty", opq.size(), 0);
    check("expq_empty", expq.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
